// File: rtl/adder_defs_pkg.sv
// Shared constants for the pipelined add/sub datapath: operation encodings
// and default geometry.
package adder_defs;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

endpackage

// File: rtl/addsub_segment.sv
// SEG_W-bit ripple-carry segment; also exposes the carry into its MSB so the
// top segment can derive signed overflow.
module addsub_segment
  import adder_defs::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SEG_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout  = carry[SEG_W];
  assign c_msb = carry[SEG_W-1];

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell, the building block of each ripple segment.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two-operand adder/subtractor: one register rank per carry segment
// plus an operand rank, global stall enable, optional saturation on overflow.
module pipelined_addsub
  import adder_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NUM_SEG = WIDTH / SEG_W;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Rank 0 holds the (already inverted for sub) operands; rank k+1 holds the
  // result of segment k plus the carry it produced.
  logic                           en;
  logic [NUM_SEG:0]               v_d, v_q;
  logic [NUM_SEG:0]               c_d, c_q;
  logic [NUM_SEG-1:0][WIDTH-1:0]  a_d, a_q;
  logic [NUM_SEG-1:0][WIDTH-1:0]  b_d, b_q;
  logic [NUM_SEG:1][WIDTH-1:0]    s_d, s_q;
  logic                           ovf_d, ovf_q;

  logic [NUM_SEG-1:0][SEG_W-1:0]  seg_sum;
  logic [NUM_SEG-1:0]             seg_cout;
  logic                           top_cmsb;

  assign en = ~v_q[NUM_SEG] | out_ready;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    logic c_msb;

    addsub_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (a_q[k][k*SEG_W +: SEG_W]),
      .b    (b_q[k][k*SEG_W +: SEG_W]),
      .cin  (c_q[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .c_msb(c_msb)
    );

    if (k == NUM_SEG-1) begin : g_top
      assign top_cmsb = c_msb;
    end else begin : g_mid
      logic cmsb_unused;
      assign cmsb_unused = c_msb;
    end
  end

  // Lower operand bits of the last rank have already been consumed.
  if (NUM_SEG > 1) begin : g_lo_sink
    logic lo_unused;
    assign lo_unused = ^{a_q[NUM_SEG-1][WIDTH-SEG_W-1:0], b_q[NUM_SEG-1][WIDTH-SEG_W-1:0]};
  end

  always_comb begin
    v_d   = {v_q[NUM_SEG-1:0], in_valid};
    c_d   = '0;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = '0;
    ovf_d = 1'b0;

    a_d[0] = in_a;
    b_d[0] = (in_op == OP_SUB) ? ~in_b : in_b;
    c_d[0] = (in_op == OP_SUB) ? 1'b1 : in_cin;

    for (int k = 0; k < NUM_SEG-1; k++) begin
      a_d[k+1] = a_q[k];
      b_d[k+1] = b_q[k];
    end

    for (int k = 1; k < NUM_SEG; k++) begin
      s_d[k+1] = s_q[k];
    end

    for (int k = 0; k < NUM_SEG; k++) begin
      s_d[k+1][k*SEG_W +: SEG_W] = seg_sum[k];
      c_d[k+1]                   = seg_cout[k];
    end

    ovf_d = top_cmsb ^ seg_cout[NUM_SEG-1];
    if (SAT && ovf_d) begin
      s_d[NUM_SEG] = a_q[NUM_SEG-1][WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[NUM_SEG];
  assign out_sum   = s_q[NUM_SEG];
  assign out_cout  = c_q[NUM_SEG];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: wrap and saturating instances driven in
// parallel, directed corner beats plus random traffic against a queue model.
module tb_pipelined_addsub;
  import adder_defs::*;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_op;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, out_cout_w, out_ovf_w;
  logic [15:0] out_sum_w;
  logic        in_ready_s, out_valid_s, out_cout_s, out_ovf_s;
  logic [15:0] out_sum_s;

  int n_cmp = 0;
  int n_err = 0;
  exp_t qw[$];
  exp_t qs[$];

  pipelined_addsub #(.WIDTH(16), .SEG_W(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_cout(out_cout_w), .out_ovf(out_ovf_w)
  );

  pipelined_addsub #(.WIDTH(16), .SEG_W(4), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_cout(out_cout_s), .out_ovf(out_ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic op);
    exp_t e;
    int   r, ua, ub;
    ua = int'(a);
    ub = int'(b);
    if (op == OP_SUB) begin
      r   = int'($signed(a)) - int'($signed(b));
      e.w = 16'(ua - ub);
      e.c = (ua >= ub);
    end else begin
      r   = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.w = 16'(ua + ub + int'(cin));
      e.c = (ua + ub + int'(cin)) > 65535;
    end
    e.o = (r > 32767) || (r < -32768);
    e.s = e.o ? (a[15] ? 16'h8000 : 16'h7FFF) : e.w;
    return e;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: everything stable at the falling edge ahead of the next rise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      qw.delete();
      qs.delete();
    end else begin
      chk("in_ready_w", in_ready_w, !(out_valid_w && !out_ready));
      chk("in_ready_s", in_ready_s, !(out_valid_s && !out_ready));
      if (out_valid_w && out_ready) begin
        if (qw.size() == 0) chk("spurious_w", 1, 0);
        else begin
          e = qw.pop_front();
          chk("sum_w", out_sum_w, e.w);
          chk("cout_w", out_cout_w, e.c);
          chk("ovf_w", out_ovf_w, e.o);
        end
      end
      if (out_valid_s && out_ready) begin
        if (qs.size() == 0) chk("spurious_s", 1, 0);
        else begin
          e = qs.pop_front();
          chk("sum_s", out_sum_s, e.s);
          chk("cout_s", out_cout_s, e.c);
          chk("ovf_s", out_ovf_s, e.o);
        end
      end
      if (in_valid && in_ready_w) qw.push_back(model(in_a, in_b, in_cin, in_op));
      if (in_valid && in_ready_s) qs.push_back(model(in_a, in_b, in_cin, in_op));
    end
  end

  task automatic one_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic op, input logic [15:0] ew,
                          input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid_w) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    if (lat != 0) begin
      chk({tag, "_valid_s"}, out_valid_s, 1);
      chk({tag, "_sum_w"}, out_sum_w, ew);
      chk({tag, "_sum_s"}, out_sum_s, es);
      chk({tag, "_cout"}, out_cout_w, ec);
      chk({tag, "_ovf"}, out_ovf_w, eo);
      chk({tag, "_ovf_s"}, out_ovf_s, eo);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  i, cyc;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_op = OP_ADD; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid_w, 0);
    chk("rst_sum", out_sum_w, 0);
    chk("rst_cout", out_cout_w, 0);
    chk("rst_ovf", out_ovf_w, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready_w, 1);

    one_beat("t1_add",   16'h00FF, 16'h0001, 1'b0, OP_ADD, 16'h0100, 16'h0100, 1'b0, 1'b0);
    one_beat("t2_wrap",  16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 16'h0000, 1'b1, 1'b0);
    one_beat("t3_ovf",   16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    one_beat("t4_sub",   16'h0003, 16'h0005, 1'b0, OP_SUB, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
    one_beat("t4_subov", 16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    one_beat("cin_add",  16'h0001, 16'h0002, 1'b1, OP_ADD, 16'h0004, 16'h0004, 1'b0, 1'b0);
    one_beat("cin_sub",  16'h0005, 16'h0003, 1'b1, OP_SUB, 16'h0002, 16'h0002, 1'b1, 1'b0);

    // Back-to-back beats with alternating downstream ready.
    i = 0; cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000; in_cin = 1'b0; in_op = OP_ADD;
    out_ready = 1'b1;
    for (int g = 0; g < 100 && i < 8; g++) begin
      @(negedge clk);
      acc = in_ready_w;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
      if (i < 8) begin
        in_a = 16'(i);
        in_b = 16'(i) << 12;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc % 2 == 0);
    end
    chk("b2b_accepts", i, 8);
    for (int g = 0; g < 60; g++) begin
      if (qw.size() == 0 && qs.size() == 0 && !out_valid_w && !out_valid_s) break;
      @(posedge clk); #1;
      cyc++;
      out_ready = (cyc % 2 == 0);
    end
    chk("b2b_drain", qw.size() + qs.size(), 0);

    // Reset with three beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_a = 16'(k + 1); in_b = 16'h0100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", out_valid_w, 0);
    chk("midrst_valid_s", out_valid_s, 0);
    chk("midrst_sum", out_sum_w, 0);
    chk("midrst_cout", out_cout_w, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale", out_valid_w | out_valid_s, 0);
    end
    one_beat("rst_next", 16'h0002, 16'h0003, 1'b0, OP_ADD, 16'h0005, 16'h0005, 1'b0, 1'b0);

    // Random traffic with random back-pressure.
    @(posedge clk); #1;
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_a     = pick_operand();
        in_b     = pick_operand();
        in_cin   = 1'($urandom);
        in_op    = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = in_valid && in_ready_w;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      if (qw.size() == 0 && qs.size() == 0 && !out_valid_w && !out_valid_s) break;
      @(posedge clk); #1;
    end
    chk("rand_drain", qw.size() + qs.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
